execute_muldiv: RTL and testbench
=================================

Name: execute_muldiv

Overview:
- RV32 M-extension execution unit in the EX stage, directly downstream of the decode stage.
- Consumes the decoded operation (alu_control) and the selected operands (opa_mux_out / opb_mux_out) captured in the ID/EX register.
- Multiplies are registered with 1-cycle latency. Divide/remainder use an iterative radix-2 restoring divider.
- busy drives the hazard unit, which stalls IF/ID while a divide is in flight.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported and verified.
- RD_W, 5, destination register index width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- valid_in  in  1  ID/EX holds a valid instruction
- alu_control  in  5  decoded operation code
- op_a  in  XLEN  operand A (rs1 value after forwarding)
- op_b  in  XLEN  operand B (rs2 value after forwarding)
- rd_in  in  RD_W  destination register of the instruction
- flush  in  1  synchronous kill from branch/jump redirect
- ready  out  1  unit can accept an M-op this cycle
- busy  out  1  M-op in flight; stall request to the hazard unit
- result  out  XLEN  M-op result
- result_rd  out  RD_W  destination register of result
- result_valid  out  1  result/result_rd valid this cycle (single-cycle pulse)

Behaviour:
- alu_control M-op encodings:
  - 5'b10000 MUL, 10001 MULH, 10010 MULHSU, 10011 MULHU
  - 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU
- Any other code is ignored and nothing is accepted; the ALU handles it.
- Accept = valid_in & ready & M-op & !flush. Acceptance cycle = cycle 0. Operands and rd_in are latched at the end of cycle 0.
- States: IDLE, DIV, FIX, DONE. ready = (IDLE | DONE). busy = (DIV | FIX).
- Transitions:
  - IDLE/DONE + accept MUL* -> DONE. result_valid in cycle 1.
  - IDLE/DONE + accept DIV*/REM* with divisor==0 or signed overflow -> DONE (fast path). result_valid in cycle 1.
  - IDLE/DONE + accept other DIV*/REM* -> DIV, iteration count = 0.
  - DIV: one quotient bit per cycle on absolute values (signed ops) or raw values (unsigned ops). After 32 iterations -> FIX.
  - FIX: negate quotient if operand signs differ (DIV only); negate remainder if the dividend is negative (REM only). -> DONE. result_valid in cycle 34.
  - DONE without accept -> IDLE.
- Multiply uses a 33x33 signed product.
  - MUL: low 32 bits.
  - MULH: A and B sign-extended, high 32 bits.
  - MULHSU: A sign-extended, B zero-extended, high 32 bits.
  - MULHU: both zero-extended, high 32 bits.
- Divide by zero: quotient = 0xFFFFFFFF; remainder = dividend. Applies to both signed and unsigned ops.
- Signed overflow (0x80000000 / 0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- result and result_rd hold their last values when result_valid = 0.
- Back-to-back: an accept in DONE is legal. A new result follows with no idle bubble for MUL.
- flush:
  - Any state -> IDLE next cycle. An in-flight or pending result is discarded and result_valid stays 0.
  - flush together with valid_in: flush wins, nothing is accepted.
- Reset (asserted anytime, including mid-divide):
  - state = IDLE; result, result_rd, result_valid, busy, iteration counter = 0; ready = 1.
  - On release, the unit is immediately able to accept.
- No downstream backpressure: result_valid is a single-cycle pulse and MEM always consumes it.

Test Plan:
- MUL 7 x 0xFFFFFFFD (-3), rd=5 -> result 0xFFFFFFEB, result_rd 5, result_valid in cycle 1 only, busy never high.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULH with the same operands -> 0x00000000. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD, with busy high cycles 1-33 and result_valid in cycle 34. REM with the same operands -> 0xFFFFFFFF.
- DIVU 0x1234 / 0 -> 0xFFFFFFFF in cycle 1. REMU 0x1234 / 0 -> 0x1234. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM with the same operands -> 0.
- DIVU 100 / 7 accepted, then flush in cycle 10 -> busy low from cycle 11, no result_valid ever for it. MUL 3 x 4 accepted in cycle 11 -> 12 in cycle 12.
- rst low in cycle 5 of a DIV -> all outputs 0 and ready=1 immediately. After release, DIV 9 / 3 -> 3 in cycle 34.

Source files
------------

// File: rtl/execute_muldiv_if.sv
// Request/response bundle between the ID/EX register and the M-extension unit.
// The master side drives the decoded M-op, the slave side returns ready/busy and results.
interface execute_muldiv_if #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
);
    logic            valid_in;
    logic [4:0]      alu_control;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [RD_W-1:0] rd_in;
    logic            flush;
    logic            ready;
    logic            busy;
    logic [XLEN-1:0] result;
    logic [RD_W-1:0] result_rd;
    logic            result_valid;

    modport master (
        output valid_in, alu_control, op_a, op_b, rd_in, flush,
        input  ready, busy, result, result_rd, result_valid
    );

    modport slave (
        input  valid_in, alu_control, op_a, op_b, rd_in, flush,
        output ready, busy, result, result_rd, result_valid
    );
endinterface

// File: rtl/execute_muldiv.sv
// RV32 M-extension execute unit: registered multiply, iterative radix-2 restoring divide.
// Latency: MUL*/fast-path div 1 cycle, normal DIV*/REM* 34 cycles (32 iterations + sign fix + done).
// Backpressure: none downstream; ready low and busy high while a divide iterates.
module execute_muldiv #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    execute_muldiv_if.slave  mif
);
    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIX, S_DONE} state_t;

    state_t          state;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0] quo_r;
    logic [XLEN-1:0] rem_r;
    logic [XLEN-1:0] dvsr_r;
    logic            is_rem_r;
    logic            neg_q_r;
    logic            neg_r_r;
    logic [RD_W-1:0] rd_r;
    logic [XLEN-1:0] result_r;
    logic [RD_W-1:0] result_rd_r;
    logic            result_valid_r;

    logic ready_c;
    assign ready_c          = (state == S_IDLE) || (state == S_DONE);
    assign mif.ready        = ready_c;
    assign mif.busy         = (state == S_DIV) || (state == S_FIX);
    assign mif.result       = result_r;
    assign mif.result_rd    = result_rd_r;
    assign mif.result_valid = result_valid_r;

    // Decode: 10xxx is an M-op; bit 2 selects divide, bit 1 remainder, bit 0 unsigned divide.
    logic is_mop, is_div, is_rem, div_signed, accept;
    assign is_mop     = (mif.alu_control[4:3] == 2'b10);
    assign is_div     = mif.alu_control[2];
    assign is_rem     = mif.alu_control[1];
    assign div_signed = ~mif.alu_control[0];
    assign accept     = mif.valid_in & ready_c & is_mop & ~mif.flush;

    // Sign-extending both operands to 2*XLEN gives the low 2*XLEN bits of the 33x33 signed product.
    logic            mul_a_sgn, mul_b_sgn;
    logic [2*XLEN-1:0] mul_a, mul_b, prod;
    logic [XLEN-1:0] mul_res;
    assign mul_a_sgn = (mif.alu_control[1:0] == 2'b01) || (mif.alu_control[1:0] == 2'b10);
    assign mul_b_sgn = (mif.alu_control[1:0] == 2'b01);
    assign mul_a     = {{XLEN{mul_a_sgn & mif.op_a[XLEN-1]}}, mif.op_a};
    assign mul_b     = {{XLEN{mul_b_sgn & mif.op_b[XLEN-1]}}, mif.op_b};
    assign prod      = mul_a * mul_b;
    assign mul_res   = (mif.alu_control[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    logic            a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0] abs_a, abs_b, fast_res;
    assign a_neg    = div_signed & mif.op_a[XLEN-1];
    assign b_neg    = div_signed & mif.op_b[XLEN-1];
    assign abs_a    = a_neg ? -mif.op_a : mif.op_a;
    assign abs_b    = b_neg ? -mif.op_b : mif.op_b;
    assign div_zero = (mif.op_b == '0);
    assign div_ovf  = div_signed && (mif.op_a == {1'b1, {(XLEN-1){1'b0}}}) && (mif.op_b == '1);

    always_comb begin
        fast_res = '0;
        if (div_zero)
            fast_res = is_rem ? mif.op_a : '1;
        else if (div_ovf)
            fast_res = is_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    // One restoring step: shift the next dividend bit into the partial remainder and try to subtract.
    logic [XLEN:0]   rem_sh, diff;
    logic [XLEN-1:0] rem_nxt, quo_nxt, fix_res;
    assign rem_sh  = {rem_r, quo_r[XLEN-1]};
    assign diff    = rem_sh - {1'b0, dvsr_r};
    assign rem_nxt = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
    assign quo_nxt = {quo_r[XLEN-2:0], ~diff[XLEN]};
    assign fix_res = is_rem_r ? (neg_r_r ? -rem_r : rem_r) : (neg_q_r ? -quo_r : quo_r);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            cnt            <= '0;
            quo_r          <= '0;
            rem_r          <= '0;
            dvsr_r         <= '0;
            is_rem_r       <= 1'b0;
            neg_q_r        <= 1'b0;
            neg_r_r        <= 1'b0;
            rd_r           <= '0;
            result_r       <= '0;
            result_rd_r    <= '0;
            result_valid_r <= 1'b0;
        end else begin
            result_valid_r <= 1'b0;
            if (mif.flush) begin
                state <= S_IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        state <= S_IDLE;
                        if (accept) begin
                            if (!is_div || div_zero || div_ovf) begin
                                result_r       <= is_div ? fast_res : mul_res;
                                result_rd_r    <= mif.rd_in;
                                result_valid_r <= 1'b1;
                                state          <= S_DONE;
                            end else begin
                                quo_r    <= abs_a;
                                rem_r    <= '0;
                                dvsr_r   <= abs_b;
                                is_rem_r <= is_rem;
                                neg_q_r  <= a_neg ^ b_neg;
                                neg_r_r  <= a_neg;
                                rd_r     <= mif.rd_in;
                                cnt      <= '0;
                                state    <= S_DIV;
                            end
                        end
                    end
                    S_DIV: begin
                        quo_r <= quo_nxt;
                        rem_r <= rem_nxt;
                        cnt   <= cnt + 1'b1;
                        if (cnt == CNT_LAST)
                            state <= S_FIX;
                    end
                    S_FIX: begin
                        result_r       <= fix_res;
                        result_rd_r    <= rd_r;
                        result_valid_r <= 1'b1;
                        cnt            <= '0;
                        state          <= S_DONE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_execute_muldiv.sv
// Bench for execute_muldiv: directed vector table, random ops against an arithmetic
// reference model, and hand-written flush / reset / back-to-back sequences.
module tb_execute_muldiv;
    localparam logic [4:0] OP_MUL    = 5'b10000;
    localparam logic [4:0] OP_MULH   = 5'b10001;
    localparam logic [4:0] OP_MULHSU = 5'b10010;
    localparam logic [4:0] OP_MULHU  = 5'b10011;
    localparam logic [4:0] OP_DIV    = 5'b10100;
    localparam logic [4:0] OP_DIVU   = 5'b10101;
    localparam logic [4:0] OP_REM    = 5'b10110;
    localparam logic [4:0] OP_REMU   = 5'b10111;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    execute_muldiv_if #(.XLEN(32), .RD_W(5)) mif ();
    execute_muldiv #(.XLEN(32), .RD_W(5)) dut (.clk(clk), .rst(rst), .mif(mif.slave));

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    // Reference: RISC-V M semantics written with plain 64-bit / native signed arithmetic.
    function automatic logic [31:0] ref_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p;
        logic [63:0] pu;
        int q;
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        sa = (op == OP_MULH || op == OP_MULHSU) ? longint'($signed(a)) : longint'({32'd0, a});
        sb = (op == OP_MULH) ? longint'($signed(b)) : longint'({32'd0, b});
        p  = sa * sb;
        pu = p;
        case (op)
            OP_MUL:                       return pu[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU: return pu[63:32];
            OP_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf)    return 32'h8000_0000;
                q = $signed(a) / $signed(b);
                return q;
            end
            OP_REM: begin
                if (b == 0) return a;
                if (ovf)    return 32'h0;
                q = $signed(a) % $signed(b);
                return q;
            end
            OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REMU: return (b == 0) ? a : a % b;
            default: return 32'h0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic sgn;
        sgn = (op == OP_DIV) || (op == OP_REM);
        if (op[2] == 1'b0) return 1;
        if (b == 0) return 1;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic idle_inputs();
        mif.valid_in    = 1'b0;
        mif.alu_control = 5'd0;
        mif.op_a        = 32'd0;
        mif.op_b        = 32'd0;
        mif.rd_in       = 5'd0;
        mif.flush       = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; issues in cycle 0 and observes cycles 1..36.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp_res, input int exp_lat,
                          input string tag);
        int got_lat = 0;
        int pulses = 0;
        int busy_err = 0;
        logic [31:0] got_res = 32'h0;
        logic [4:0]  got_rd = 5'h0;
        mif.valid_in    = 1'b1;
        mif.alu_control = op;
        mif.op_a        = a;
        mif.op_b        = b;
        mif.rd_in       = rd;
        step();
        mif.valid_in = 1'b0;
        for (int c = 1; c <= 36; c++) begin
            if (mif.result_valid === 1'b1) begin
                pulses++;
                if (got_lat == 0) begin
                    got_lat = c;
                    got_res = mif.result;
                    got_rd  = mif.result_rd;
                end
            end
            if (mif.busy !== (c < exp_lat)) busy_err++;
            if (mif.ready !== ~mif.busy) busy_err++;
            step();
        end
        check({tag, " latency"}, 32'(got_lat), 32'(exp_lat));
        check({tag, " result"}, got_res, exp_res);
        check({tag, " rd"}, {27'd0, got_rd}, {27'd0, rd});
        check({tag, " pulses"}, 32'(pulses), 32'd1);
        check({tag, " busy/ready"}, 32'(busy_err), 32'd0);
        check({tag, " hold"}, mif.result, exp_res);
    endtask

    vec_t vecs[16];

    initial begin
        vecs[0]  = '{OP_MUL,    32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 1};
        vecs[1]  = '{OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, 1};
        vecs[2]  = '{OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  32'h0000_0000, 1};
        vecs[3]  = '{OP_MULHSU, 32'hFFFF_FFFF,  32'd2,         5'd8,  32'hFFFF_FFFF, 1};
        vecs[4]  = '{OP_MULH,   32'h8000_0000,  32'h8000_0000, 5'd9,  32'h4000_0000, 1};
        vecs[5]  = '{OP_DIV,    32'hFFFF_FFF9,  32'd2,         5'd10, 32'hFFFF_FFFD, 34};
        vecs[6]  = '{OP_REM,    32'hFFFF_FFF9,  32'd2,         5'd11, 32'hFFFF_FFFF, 34};
        vecs[7]  = '{OP_DIVU,   32'h1234,       32'd0,         5'd12, 32'hFFFF_FFFF, 1};
        vecs[8]  = '{OP_REMU,   32'h1234,       32'd0,         5'd13, 32'h0000_1234, 1};
        vecs[9]  = '{OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 1};
        vecs[10] = '{OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd15, 32'h0000_0000, 1};
        vecs[11] = '{OP_DIVU,   32'd100,        32'd7,         5'd16, 32'd14,        34};
        vecs[12] = '{OP_REMU,   32'd100,        32'd7,         5'd17, 32'd2,         34};
        vecs[13] = '{OP_DIV,    32'd100,        32'hFFFF_FFF9, 5'd18, 32'hFFFF_FFF2, 34};
        vecs[14] = '{OP_REM,    32'hFFFF_FF9C,  32'd7,         5'd19, 32'hFFFF_FFFE, 34};
        vecs[15] = '{OP_DIV,    32'h8000_0000,  32'd2,         5'd20, 32'hC000_0000, 34};

        idle_inputs();
        rst = 1'b0;
        #23;
        check("reset ready",        {31'd0, mif.ready},        32'd1);
        check("reset busy",         {31'd0, mif.busy},         32'd0);
        check("reset result_valid", {31'd0, mif.result_valid}, 32'd0);
        check("reset result",       mif.result,                32'd0);
        check("reset result_rd",    {27'd0, mif.result_rd},    32'd0);
        rst = 1'b1;
        step();

        foreach (vecs[i])
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, vecs[i].lat,
                   $sformatf("vec%0d", i));

        // Non-M opcode must be ignored.
        mif.valid_in = 1'b1; mif.alu_control = 5'b00011; mif.op_a = 32'd5; mif.op_b = 32'd6;
        step();
        mif.valid_in = 1'b0;
        check("non-mop valid", {31'd0, mif.result_valid}, 32'd0);
        check("non-mop ready", {31'd0, mif.ready},        32'd1);
        step();

        // Back-to-back MULs: accept in DONE, no bubble.
        mif.valid_in = 1'b1; mif.alu_control = OP_MUL; mif.op_a = 32'd6; mif.op_b = 32'd7; mif.rd_in = 5'd1;
        step();
        check("b2b first valid",  {31'd0, mif.result_valid}, 32'd1);
        check("b2b first result", mif.result,                32'd42);
        check("b2b first ready",  {31'd0, mif.ready},        32'd1);
        mif.alu_control = OP_MULHU; mif.op_a = 32'hFFFF_FFFF; mif.op_b = 32'd2; mif.rd_in = 5'd2;
        step();
        mif.valid_in = 1'b0;
        check("b2b second valid",  {31'd0, mif.result_valid}, 32'd1);
        check("b2b second result", mif.result,                32'd1);
        check("b2b second rd",     {27'd0, mif.result_rd},    32'd2);
        step();
        check("b2b after valid", {31'd0, mif.result_valid}, 32'd0);

        // Flush mid-divide in cycle 10, then MUL accepted in cycle 11.
        begin
            int stray = 0;
            mif.valid_in = 1'b1; mif.alu_control = OP_DIVU; mif.op_a = 32'd100; mif.op_b = 32'd7; mif.rd_in = 5'd3;
            step();
            mif.valid_in = 1'b0;
            for (int c = 1; c <= 9; c++) begin
                if (mif.result_valid === 1'b1) stray++;
                step();
            end
            mif.flush = 1'b1;
            step();
            mif.flush = 1'b0;
            check("flush busy low", {31'd0, mif.busy},  32'd0);
            check("flush ready",    {31'd0, mif.ready}, 32'd1);
            if (mif.result_valid === 1'b1) stray++;
            mif.valid_in = 1'b1; mif.alu_control = OP_MUL; mif.op_a = 32'd3; mif.op_b = 32'd4; mif.rd_in = 5'd4;
            step();
            mif.valid_in = 1'b0;
            check("post-flush mul valid",  {31'd0, mif.result_valid}, 32'd1);
            check("post-flush mul result", mif.result,                32'd12);
            check("post-flush mul rd",     {27'd0, mif.result_rd},    32'd4);
            step();
            for (int c = 0; c < 40; c++) begin
                if (mif.result_valid === 1'b1) stray++;
                step();
            end
            check("flushed div no result", 32'(stray), 32'd0);
        end

        // Flush together with valid_in: nothing accepted.
        mif.flush = 1'b1; mif.valid_in = 1'b1; mif.alu_control = OP_MUL; mif.op_a = 32'd9; mif.op_b = 32'd9;
        step();
        idle_inputs();
        check("flush+valid no result", {31'd0, mif.result_valid}, 32'd0);
        step();
        check("flush+valid still none", {31'd0, mif.result_valid}, 32'd0);

        // Reset in cycle 5 of a divide.
        mif.valid_in = 1'b1; mif.alu_control = OP_DIV; mif.op_a = 32'd1000; mif.op_b = 32'd3; mif.rd_in = 5'd9;
        step();
        mif.valid_in = 1'b0;
        for (int c = 1; c < 5; c++) step();
        check("pre-reset busy", {31'd0, mif.busy}, 32'd1);
        rst = 1'b0;
        #1;
        check("mid-reset ready",  {31'd0, mif.ready},        32'd1);
        check("mid-reset busy",   {31'd0, mif.busy},         32'd0);
        check("mid-reset valid",  {31'd0, mif.result_valid}, 32'd0);
        check("mid-reset result", mif.result,                32'd0);
        check("mid-reset rd",     {27'd0, mif.result_rd},    32'd0);
        #2;
        rst = 1'b1;
        step();
        run_op(OP_DIV, 32'd9, 32'd3, 5'd21, 32'd3, 34, "post-reset div");

        // Randomized ops against the reference model.
        for (int n = 0; n < 120; n++) begin
            logic [4:0]  op;
            logic [31:0] a, b;
            logic [4:0]  rd;
            op = 5'b10000 | 5'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            rd = 5'($urandom_range(0, 31));
            run_op(op, a, b, rd, ref_model(op, a, b), ref_latency(op, a, b),
                   $sformatf("rand%0d op%02h a%08h b%08h", n, op, a, b));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
